// File: rtl/calc_display_pkg.sv
// Shared display constants and scan state encoding for the calculator's
// 7-segment display path.
package calc_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    GUARD,
    SHOW
  } scan_state_t;

endpackage

// File: rtl/BCDToLED.sv
// BCD digit to active-low segment pattern (a..g on bits 0..6); codes above 9
// produce an unlit digit.
module BCDToLED
  import calc_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = 7'h40;
      4'd1: seg = 7'h79;
      4'd2: seg = 7'h24;
      4'd3: seg = 7'h30;
      4'd4: seg = 7'h19;
      4'd5: seg = 7'h12;
      4'd6: seg = 7'h02;
      4'd7: seg = 7'h78;
      4'd8: seg = 7'h00;
      4'd9: seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 7-segment scan controller: one shared decoder, guarded
// anode slots, and display updates committed only at frame boundaries.
module seven_seg_scanner
  import calc_display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = 50000,
  parameter int GUARD_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    blank_lz,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    frame_tick
);

  localparam int CW = $clog2(SLOT_CYCLES);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  scan_state_t            state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic [IW-1:0]          idx, idx_nxt;
  logic                   tick_nxt;
  logic [4*NUM_DIGITS-1:0] active, pending;
  logic                   pend_v;
  logic                   accept, commit;
  logic [3:0]             digits [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]  lz;
  logic                   all_zero;
  logic [3:0]             cur_digit;
  logic [6:0]             dec_seg;
  logic                   lit, blank;
  logic [NUM_DIGITS-1:0]  an_nxt;
  logic [6:0]             seg_nxt;

  assign load_ready = !pend_v;
  assign accept     = load_valid && !pend_v;
  // IDLE has no frame to tear, so a pending load lands straight away there.
  assign commit     = pend_v && (frame_tick || state == IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    tick_nxt  = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      idx_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = GUARD;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
        GUARD: begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == GUARD_LAST) state_nxt = SHOW;
        end
        SHOW: begin
          if (cnt == SLOT_LAST) begin
            cnt_nxt   = '0;
            state_nxt = GUARD;
            if (idx == IDX_LAST) begin
              idx_nxt  = '0;
              tick_nxt = 1'b1;
            end else begin
              idx_nxt = idx + 1'b1;
            end
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // lz[i] is set when digit i and every more-significant digit are zero.
  always_comb begin
    all_zero = 1'b1;
    lz       = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      digits[i] = active[4*i +: 4];
      all_zero  = all_zero && (active[4*i +: 4] == 4'd0);
      lz[i]     = all_zero;
    end
  end

  assign cur_digit = digits[idx];

  BCDToLED u_dec (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

  always_comb begin
    lit     = (state == SHOW) && enable;
    blank   = (cur_digit > 4'd9) || (blank_lz && (idx != '0) && lz[idx]);
    an_nxt  = lit ? ~(NUM_DIGITS'(1) << idx) : '1;
    seg_nxt = (lit && !blank) ? dec_seg : SEG_BLANK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      frame_tick <= 1'b0;
      an         <= '1;
      seg        <= SEG_BLANK;
      active     <= {NUM_DIGITS{BCD_BLANK}};
      pending    <= {NUM_DIGITS{BCD_BLANK}};
      pend_v     <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      frame_tick <= tick_nxt;
      an         <= an_nxt;
      seg        <= seg_nxt;
      if (commit) active <= pending;
      if (accept) begin
        pending <= load_data;
        pend_v  <= 1'b1;
      end else if (commit) begin
        pend_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner: a scan-time model checked every
// cycle, plus directed literal expectations on display contents.
module tb_seven_seg_scanner;

  localparam int N = 4;
  localparam int S = 8;
  localparam int G = 2;
  localparam logic [6:0] SEG_TBL [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                          7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        blank_lz = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = 16'h0;
  logic        load_ready;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        frame_tick;

  int checks = 0;
  int passes = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  seven_seg_scanner #(
    .NUM_DIGITS   (N),
    .SLOT_CYCLES  (S),
    .GUARD_CYCLES (G)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .blank_lz   (blank_lz),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .an         (an),
    .seg        (seg),
    .frame_tick (frame_tick)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    $display("[TB] FAIL %s: timed out at %0t", name, $time);
  endtask

  // Segment pattern digit d of a 16-bit BCD value must show.
  function automatic logic [6:0] seg_of(input logic [15:0] val, input int d, input bit lz);
    int code;
    code = int'((val >> (4*d)) & 16'hF);
    if (code > 9) return 7'h7F;
    if (lz && d > 0 && (val >> (4*d)) == 16'h0) return 7'h7F;
    return SEG_TBL[code];
  endfunction

  // Model: m_k is scan time since scanning started, so slot, digit and phase
  // are plain division/modulo of it.
  bit          m_run, m_pv, m_tick, m_accept, m_commit;
  int          m_k, m_d;
  logic [15:0] m_act, m_pend;
  logic [3:0]  m_an;
  logic [6:0]  m_seg;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_k = 0; m_pv = 0; m_tick = 0;
      m_act = 16'hFFFF; m_pend = 16'hFFFF;
      m_an = 4'hF; m_seg = 7'h7F;
    end else begin
      m_accept = load_valid && !m_pv;
      m_commit = m_pv && (m_tick || !m_run);
      if (m_run && enable && (m_k % S) >= G) begin
        m_d   = (m_k / S) % N;
        m_an  = ~(4'b0001 << m_d);
        m_seg = seg_of(m_act, m_d, blank_lz);
      end else begin
        m_an  = 4'hF;
        m_seg = 7'h7F;
      end
      m_tick = m_run && enable && (m_k == N*S - 1);
      if (m_commit) m_act = m_pend;
      if (m_accept) begin
        m_pend = load_data;
        m_pv   = 1;
      end else if (m_commit) begin
        m_pv = 0;
      end
      if (!enable) begin
        m_run = 0; m_k = 0;
      end else if (!m_run) begin
        m_run = 1; m_k = 0;
      end else begin
        m_k = (m_k + 1) % (N*S);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      checkOutput("an", 32'(an), 32'(m_an));
      checkOutput("seg", 32'(seg), 32'(m_seg));
      checkOutput("frame_tick", 32'(frame_tick), 32'(m_tick));
      checkOutput("load_ready", 32'(load_ready), 32'(!m_pv));
    end
  end

  task automatic applyStimulus(input logic [15:0] data);
    int n;
    @(negedge clk);
    load_data  = data;
    load_valid = 1'b1;
    n = 0;
    while (!load_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) timeoutFail("load_accept");
    @(negedge clk);
    load_valid = 1'b0;
    checkOutput("ready_low_after_accept", 32'(load_ready), 32'd0);
  endtask

  task automatic wait_an(input logic [3:0] want);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (an !== want && n < 200);
    if (an !== want) timeoutFail("wait_an");
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_tick !== 1'b1 && n < 200);
    if (frame_tick !== 1'b1) timeoutFail("wait_tick");
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    checkOutput("reset_an", 32'(an), 32'hF);
    checkOutput("reset_seg", 32'(seg), 32'h7F);
    checkOutput("reset_ready", 32'(load_ready), 32'd1);
    checkOutput("reset_tick", 32'(frame_tick), 32'd0);
    rst_n  = 1'b1;
    cmp_on = 1'b1;

    // Empty display scanning; frame period.
    enable = 1'b1;
    wait_an(4'hE);
    checkOutput("empty_digit0", 32'(seg), 32'h7F);
    wait_tick();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_tick !== 1'b1 && n < 100);
    checkOutput("frame_period", 32'(n), 32'd32);

    // 0012 without leading-zero blanking.
    applyStimulus(16'h0012);
    wait_tick();
    checkOutput("ready_on_commit_cycle", 32'(load_ready), 32'd0);
    @(negedge clk);
    checkOutput("ready_after_commit", 32'(load_ready), 32'd1);
    wait_an(4'hE); checkOutput("d0_of_0012", 32'(seg), 32'h24);
    wait_an(4'hD); checkOutput("d1_of_0012", 32'(seg), 32'h79);
    wait_an(4'hB); checkOutput("d2_of_0012", 32'(seg), 32'h40);
    wait_an(4'h7); checkOutput("d3_of_0012", 32'(seg), 32'h40);

    // Leading-zero blanking on.
    @(negedge clk);
    blank_lz = 1'b1;
    wait_an(4'hB); checkOutput("lz_d2_of_0012", 32'(seg), 32'h7F);
    wait_an(4'h7); checkOutput("lz_d3_of_0012", 32'(seg), 32'h7F);
    wait_an(4'hD); checkOutput("lz_d1_of_0012", 32'(seg), 32'h79);
    applyStimulus(16'h0000);
    wait_tick();
    wait_an(4'hE); checkOutput("lz_d0_of_0000", 32'(seg), 32'h40);
    wait_an(4'hD); checkOutput("lz_d1_of_0000", 32'(seg), 32'h7F);

    // Second load held valid while the first is still pending.
    applyStimulus(16'h1234);
    applyStimulus(16'h9999);
    wait_an(4'hE); checkOutput("d0_of_1234", 32'(seg), 32'h19);
    wait_an(4'h7); checkOutput("d3_of_1234", 32'(seg), 32'h79);
    wait_tick();
    wait_an(4'hE); checkOutput("d0_of_9999", 32'(seg), 32'h10);
    wait_an(4'h7); checkOutput("d3_of_9999", 32'(seg), 32'h10);

    // Drop enable while digit 2 is lit, then restart.
    wait_an(4'hB);
    enable = 1'b0;
    @(negedge clk);
    checkOutput("disable_an", 32'(an), 32'hF);
    checkOutput("disable_seg", 32'(seg), 32'h7F);
    repeat (3) @(negedge clk);
    enable = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      if (an === 4'hF) n++;
    end while (an === 4'hF && n < 50);
    checkOutput("reenable_dark_cycles", 32'(n), 32'd3);
    checkOutput("reenable_digit0", 32'(an), 32'hE);

    // Asynchronous reset mid-slot with a load still pending.
    applyStimulus(16'h5678);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_an", 32'(an), 32'hF);
    checkOutput("async_rst_seg", 32'(seg), 32'h7F);
    checkOutput("async_rst_ready", 32'(load_ready), 32'd1);
    checkOutput("async_rst_tick", 32'(frame_tick), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_an(4'hE); checkOutput("post_rst_d0_blank", 32'(seg), 32'h7F);
    wait_an(4'h7); checkOutput("post_rst_d3_blank", 32'(seg), 32'h7F);

    cmp_on = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Time-multiplexed scan controller for the calculator's multi-digit 7-segment display. It shares one BCD-to-segment decoder across `NUM_DIGITS` digit positions, cycling a one-hot active-low anode select with anti-ghosting guard time. It accepts new display contents through a valid/ready handshake and commits them only on frame boundaries, so a frame never shows a mix of old and new digits. It sits between the calculator result/entry logic and the board display pins.

## Interface
- `NUM_DIGITS`, 4, number of digit positions, 2..8; digit 0 is least significant.
- `SLOT_CYCLES`, 50000, clock cycles each digit slot lasts, ≥ 4.
- `GUARD_CYCLES`, 500, anodes-off cycles at the start of each slot, 1..`SLOT_CYCLES`-2.
- `clk` in 1: single clock; all state is on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `enable` in 1: scanning on when high.
- `blank_lz` in 1: leading-zero blanking on when high.
- `load_valid` in 1: `load_data` is valid.
- `load_ready` out 1: the block can accept a load.
- `load_data` in 4*`NUM_DIGITS`: BCD digits, digit i at bits [4i+3:4i]. Code 4'hF means blank; codes 10..14 are also shown blank.
- `an` out `NUM_DIGITS`: digit select, active-low, one-hot or all-ones.
- `seg` out 7: segments a..g on bits 0..6, active-low.
- `frame_tick` out 1: one-cycle pulse when the scan wraps from digit `NUM_DIGITS`-1 to digit 0.

## Operation
- Registers:
  - `active`: the digits currently displayed. Reset value is all 4'hF.
  - `pending` plus a `pend_v` flag.
  - Slot counter `cnt`, range 0..`SLOT_CYCLES`-1.
  - Digit index `idx`.
  - State.
- Load handshake:
  - A transfer occurs when `load_valid` and `load_ready` are both high.
  - The data goes to `pending` and `pend_v` is set.
  - `load_ready` = !`pend_v`.
- Commit:
  - While enabled, `pending` is copied to `active` on the cycle `frame_tick` is asserted; `pend_v` clears on that same cycle.
  - While in IDLE, `pending` is copied to `active` on the cycle after acceptance.
- States:
  - IDLE: `an` is all ones, `seg` = 7'h7F, and `cnt` and `idx` are held at 0. Go to GUARD when `enable`=1.
  - GUARD: `an` is all ones. `cnt` increments. When `cnt`=`GUARD_CYCLES`-1, go to SHOW.
  - SHOW: `an` has only bit `idx` low. `seg` is the decoded `active` digit `idx`. When `cnt`=`SLOT_CYCLES`-1:
    - `cnt` goes to 0.
    - `idx` increments; it wraps from `NUM_DIGITS`-1 to 0, and `frame_tick` fires on the wrap.
    - The next state is GUARD.
- `enable` falling, in any state: the next state is IDLE and `cnt` and `idx` clear. No `frame_tick` is generated.
- Blanking: `seg` = 7'h7F when any of these holds:
  - The digit code is greater than 9.
  - `blank_lz`=1, the digit index is greater than 0, and the digit and every more-significant digit are 0.
- Digit 0 is always shown, so an all-zero value displays "0".

## Timing
- Reset values: `an` all ones, `seg` 7'h7F, `load_ready` 1, `frame_tick` 0, state IDLE.
- Reset asserted mid-operation clears everything immediately, including `pend_v`.
- `an` and `seg` are both registered and change in the same cycle, so no glitch is visible between them.
- Decode is one pipeline stage: `seg` reflects `active` and `idx` as they were on the previous cycle. Anode timing is aligned to that stage.
- Slot cycle budget:
  - The slot lasts exactly `SLOT_CYCLES` cycles: `GUARD_CYCLES` with anodes off, then `SLOT_CYCLES`-`GUARD_CYCLES` with the digit lit.
  - A frame lasts `NUM_DIGITS`*`SLOT_CYCLES` cycles.
- Load near a frame boundary:
  - A load accepted on the `frame_tick` cycle is not committed in that cycle; it waits for the next frame.
  - `load_ready` returns high the cycle after a commit.
- Back-to-back loads: at most one load is accepted per frame while scanning.

## Structure
- Shared package `calc_display_pkg` holds:
  - `SEG_BLANK` = 7'h7F.
  - `BCD_BLANK` = 4'hF.
  - The scan state enum {IDLE, GUARD, SHOW}.
- Sub-module: the team's `BCDToLED` decoder, instantiated once. Its output is forced to `SEG_BLANK` by the blanking logic before the output register.

## Test plan
Bench parameters: `NUM_DIGITS`=4, `SLOT_CYCLES`=8, `GUARD_CYCLES`=2.
- Reset, then `enable`=1 with no load: every slot shows `seg`=7'h7F. `an` sequence per slot is 2 cycles of 4'hF, then 6 cycles of 4'hE, then 4'hD, 4'hB, 4'h7. `frame_tick` pulses every 32 cycles.
- Load 16'h0012 with `blank_lz`=0:
  - After the next `frame_tick`, digit 0 shows 7'h24 and digit 1 shows 7'h79.
  - Digits 2 and 3 show 7'h40.
  - `load_ready` is low from acceptance until the cycle after the commit.
- Same load with `blank_lz`=1: digits 2 and 3 show 7'h7F. Loading 16'h0000 shows 7'h40 on digit 0 only.
- Second load 16'h9999 mid-frame while `pend_v`=1 and `load_valid` is held high: it is not accepted until `load_ready` returns high. No frame ever mixes digits of two loads.
- `enable` dropped in SHOW of digit 2: the next cycle gives `an`=4'hF and `seg`=7'h7F. On re-enable, scanning restarts at digit 0 with GUARD.
- `rst_n` pulsed low mid-SHOW, asynchronously between clock edges: outputs go to their reset values immediately and `active` is all blank.
